icache_assoc: RTL
=================

# icache_assoc

Parametrised set-associative successor to the direct-mapped instruction cache, sitting between the fetch stage and the shared memory bus.
- Serves combinational hits on 64-bit blocks and tracks one outstanding miss through an explicit FSM.
- Replaces lines by tree pseudo-LRU and hands each evicted valid line to the victim cache.
- Yields the bus to the data cache whenever the data cache is driving a command.

## Interface
Parameters:
- NUM_SETS, 16, number of sets; power of 2, ≥2.
- NUM_WAYS, 2, ways per set; one of 1, 2, 4.
- ADDR_BITS, 16, low address bits cached. Upper address bits are ignored, as in the current cache.

Ports (clock, reset: one clock; reset is synchronous and active-high):
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rollback  in  1  pipeline squash; the fetch address changes next cycle.
- Imem2proc_response  in  4  memory acceptance tag; 0 means the request was rejected.
- Imem2proc_data  in  64  returned block.
- Imem2proc_tag  in  4  tag of the returned block; 0 means no data this cycle.
- vcachehit  in  1  the victim cache holds the current address.
- proc2Icache_addr  in  `XLEN  fetch address.
- proc2Dmem_command  in  2  data cache bus command; any value other than BUS_NONE means the data cache owns the bus.
- proc2Imem_command  out  2  BUS_LOAD or BUS_NONE.
- proc2Imem_addr  out  `XLEN  block-aligned miss address.
- Icache_data_out  out  64  hit data.
- Icache_valid_out  out  1  hit.
- victimen  out  1  an eviction is happening this cycle.
- victimidx  out  $clog2(NUM_SETS)  set index of the evicted line.
- icache_vdata  out  ICACHE_PACKET  evicted line.

## Operation
Address split, all taken from addr[ADDR_BITS-1:0]:
- offset = bits [2:0].
- set = the next $clog2(NUM_SETS) bits.
- tag = the remaining bits up to ADDR_BITS-1.

Hit path (combinational):
- Icache_valid_out = 1 when any way in the set is valid and its tag matches.
- Icache_data_out = data of the matching way; otherwise it is don't-care.
- Each clock edge with a hit updates that set's PLRU bits so they point away from the hit way.

FSM states: IDLE, REQ, WAIT.
- IDLE → REQ when the address misses and vcachehit is 0.
- REQ drives BUS_LOAD only when proc2Dmem_command == BUS_NONE and rollback is 0.
  - REQ → WAIT when Imem2proc_response != 0; the response is latched as mem_tag.
  - REQ stays in REQ (retry) when the response is 0 or the data cache owns the bus.
  - REQ → IDLE on rollback, or when the address changes so that the new address hits.
- The miss address (set and tag) is captured when entering REQ. While in REQ, the captured address re-tracks any changed fetch address.
- WAIT holds until Imem2proc_tag == mem_tag (with mem_tag != 0). On that cycle:
  - The block is written into the PLRU victim way of the captured set; tag updated, valid set.
  - PLRU is updated; FSM → IDLE; mem_tag is cleared.
- Rollback during WAIT does not abort the fill: the line is still installed for its own address. A new miss cannot issue until the fill completes.

Victim path:
- On the fill cycle, if the chosen way is valid, victimen = 1, victimidx = set, and icache_vdata = that way's old packet.
- Otherwise all three are 0.

Way selection: invalid ways are chosen first, lowest index wins; otherwise the PLRU way. With NUM_WAYS = 1 there are no PLRU bits.

## Timing
- Reset values: all lines invalid, PLRU bits 0, state IDLE, mem_tag 0.
- Output values during reset: proc2Imem_command = BUS_NONE, Icache_valid_out = 0, victimen = 0, victimidx = 0, icache_vdata = 0.
- Hit latency: 0 cycles (same cycle as the address).
- Miss: BUS_LOAD goes out on the cycle after the miss is detected, at the earliest. The line is visible as a hit on the cycle after the matching Imem2proc_tag.
- proc2Imem_addr = {addr[`XLEN-1:3], 3'b0} of the captured miss address.
- Simultaneous fill and hit in the same set: the fill's PLRU update wins.
- Reset in WAIT: the response is dropped and no line is written.

## Configuration
ICACHE_PREFETCH_EN, next-line prefetch.

When defined:
- After a demand fill, the FSM enters PF_REQ for address+8, unless that line is already present.
- PF_REQ and PF_WAIT behave like REQ and WAIT and fill the same way.
- A demand miss arriving in PF_REQ preempts the prefetch.
- A demand miss arriving in PF_WAIT waits for the prefetch fill to complete.
- Rollback cancels PF_REQ.

When not defined: the PF states are absent and behaviour is exactly as above.

## Structure
- ICACHE_PACKET (data, tags, valids), the ICACHE_STATE enum, and the BUS_* commands belong in sys_defs.
- The tag width is derived locally from ADDR_BITS, NUM_SETS and the 3 offset bits.
- One sub-module, plru_tree: it takes the current PLRU bits plus hit/fill way and returns the next bits and the victim way. It is instantiated per set or time-shared on the accessed set.

## Test plan
- Reset, then fetch 0x0000 → miss; BUS_LOAD to 0x0000 next cycle; response 3, data tag 3 with 0xDEAD_BEEF → hit on 0x0000 the following cycle.
- NUM_WAYS=2: fill 0x0000 and 0x0100 (same set), touch 0x0000, then miss 0x0200 → way holding 0x0100 is evicted; victimen=1 with that tag.
- proc2Dmem_command = BUS_LOAD for 3 cycles during a miss → proc2Imem_command stays BUS_NONE for those 3 cycles, then BUS_LOAD.
- Imem2proc_response = 0 twice → the request is re-driven each cycle until response 5 is accepted.
- Rollback in WAIT → the fill still lands; the line is valid; no second request issued.
- With ICACHE_PREFETCH_EN: demand miss on 0x0040 → after its fill, BUS_LOAD to 0x0048 without a fetch request; later fetch of 0x0048 hits.

Source files
------------

// File: rtl/icache_assoc_pkg.sv
// Shared definitions for the set-associative icache: bus commands, line packet, FSM states.
// PF_REQ/PF_WAIT exist only when ICACHE_PREFETCH_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif
package icache_assoc_pkg;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  // Packet tag field is wide enough for any ADDR_BITS/NUM_SETS split; tags are zero-extended.
  localparam int PKT_TAG_W = `XLEN - 3;

  typedef struct packed {
    logic [63:0]          data;
    logic [PKT_TAG_W-1:0] tags;
    logic                 valids;
  } ICACHE_PACKET;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT
`ifdef ICACHE_PREFETCH_EN
    ,
    PF_REQ,
    PF_WAIT
`endif
  } ICACHE_STATE;
endpackage

// File: rtl/icache_assoc_plru_tree.sv
// Tree pseudo-LRU for one set: bit value names the half holding the victim.
// An access points every node on its path away from the accessed way.
module plru_tree #(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = 1,
  parameter int PLRU_W   = 1
) (
  input  logic [PLRU_W-1:0] i_bits,
  input  logic              i_upd,
  input  logic [WAY_W-1:0]  i_way,
  output logic [PLRU_W-1:0] o_next,
  output logic [WAY_W-1:0]  o_victim
);
  if (NUM_WAYS == 4) begin : g_w4
    always_comb begin
      o_next = i_bits;
      if (i_upd) begin
        o_next[0] = ~i_way[1];
        if (i_way[1]) o_next[2] = ~i_way[0];
        else          o_next[1] = ~i_way[0];
      end
    end
    assign o_victim = i_bits[0] ? {1'b1, i_bits[2]} : {1'b0, i_bits[1]};
  end else if (NUM_WAYS == 2) begin : g_w2
    assign o_next   = i_upd ? ~i_way : i_bits;
    assign o_victim = i_bits;
  end else begin : g_w1
    assign o_next   = i_bits & {PLRU_W{~i_upd | ~|i_way}};
    assign o_victim = '0;
  end
endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational hits, one outstanding miss, PLRU replacement,
// evicted lines reported to the victim cache. ICACHE_PREFETCH_EN adds next-line prefetch.
`ifndef XLEN
`define XLEN 32
`endif
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 2,
  parameter int ADDR_BITS = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rollback,
  input  logic [3:0]                  Imem2proc_response,
  input  logic [63:0]                 Imem2proc_data,
  input  logic [3:0]                  Imem2proc_tag,
  input  logic                        vcachehit,
  input  logic [`XLEN-1:0]            proc2Icache_addr,
  input  logic [1:0]                  proc2Dmem_command,
  output logic [1:0]                  proc2Imem_command,
  output logic [`XLEN-1:0]            proc2Imem_addr,
  output logic [63:0]                 Icache_data_out,
  output logic                        Icache_valid_out,
  output logic                        victimen,
  output logic [$clog2(NUM_SETS)-1:0] victimidx,
  output ICACHE_PACKET                icache_vdata
);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_BITS - 3 - SET_W;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int PLRU_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
  localparam int BLK_W  = `XLEN - 3;

  ICACHE_STATE         r_state;
  logic [3:0]          r_mem_tag;
  logic [`XLEN-1:3]    r_miss_addr;
  logic [63:0]         r_data  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [PLRU_W-1:0]   r_plru  [NUM_SETS];

  logic [SET_W-1:0]  w_set, w_fset;
  logic [TAG_W-1:0]  w_tag, w_ftag;
  logic              w_hit, w_fill, w_bus_go, w_inv_found, w_evict, w_in_req, w_in_wait;
  logic [WAY_W-1:0]  w_hit_way, w_inv_way, w_fill_way;
  logic [63:0]       w_hit_data;
  logic [PLRU_W-1:0] w_plru_nxt [NUM_SETS];
  logic [WAY_W-1:0]  w_plru_vic [NUM_SETS];
  logic              w_unused_ok;

  assign w_set       = proc2Icache_addr[3 +: SET_W];
  assign w_tag       = proc2Icache_addr[ADDR_BITS-1 : 3+SET_W];
  assign w_fset      = r_miss_addr[3 +: SET_W];
  assign w_ftag      = r_miss_addr[ADDR_BITS-1 : 3+SET_W];
  assign w_unused_ok = &{1'b0, proc2Icache_addr[2:0]};

  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_hit_data = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (!w_hit && r_valid[w_set][w] && r_tag[w_set][w] == w_tag) begin
        w_hit      = 1'b1;
        w_hit_way  = WAY_W'(w);
        w_hit_data = r_data[w_set][w];
      end
  end

  // Invalid ways first (lowest index wins), otherwise the set's PLRU victim.
  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!r_valid[w_fset][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
  end
  assign w_fill_way = w_inv_found ? w_inv_way : w_plru_vic[w_fset];

`ifdef ICACHE_PREFETCH_EN
  logic [`XLEN-1:3] w_pf_blk;
  logic             w_pf_present;
  assign w_pf_blk = r_miss_addr + BLK_W'(1);
  always_comb begin
    w_pf_present = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (r_valid[w_pf_blk[3 +: SET_W]][w] &&
          r_tag[w_pf_blk[3 +: SET_W]][w] == w_pf_blk[ADDR_BITS-1 : 3+SET_W])
        w_pf_present = 1'b1;
  end
  // A pending demand miss suppresses the prefetch request so the bus is not wasted on it.
  assign w_in_req  = (r_state == REQ) || (r_state == PF_REQ && (w_hit || vcachehit));
  assign w_in_wait = (r_state == WAIT) || (r_state == PF_WAIT);
`else
  assign w_in_req  = (r_state == REQ);
  assign w_in_wait = (r_state == WAIT);
`endif

  assign w_bus_go = w_in_req && proc2Dmem_command == BUS_NONE && !rollback;
  assign w_fill   = w_in_wait && r_mem_tag != 4'd0 && Imem2proc_tag == r_mem_tag;
  assign w_evict  = w_fill && r_valid[w_fset][w_fill_way];

  // Fill and hit to the same set: the fill's way drives the update.
  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    logic w_fill_here, w_upd;
    assign w_fill_here = w_fill && w_fset == SET_W'(s);
    assign w_upd       = w_fill_here || (w_hit && w_set == SET_W'(s));
    plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W), .PLRU_W(PLRU_W)) u_plru (
      .i_bits   (r_plru[s]),
      .i_upd    (w_upd),
      .i_way    (w_fill_here ? w_fill_way : w_hit_way),
      .o_next   (w_plru_nxt[s]),
      .o_victim (w_plru_vic[s])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_tag   <= '0;
      r_miss_addr <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SETS; s++) r_plru[s] <= w_plru_nxt[s];
      if (w_fill) r_valid[w_fset][w_fill_way] <= 1'b1;
      case (r_state)
        IDLE:
          if (!w_hit && !vcachehit) begin
            r_state     <= REQ;
            r_miss_addr <= proc2Icache_addr[`XLEN-1:3];
          end
        REQ:
          if (rollback || w_hit) r_state <= IDLE;
          else if (w_bus_go && Imem2proc_response != 4'd0) begin
            r_state   <= WAIT;
            r_mem_tag <= Imem2proc_response;
          end else r_miss_addr <= proc2Icache_addr[`XLEN-1:3];
        WAIT:
          if (w_fill) begin
            r_mem_tag <= '0;
`ifdef ICACHE_PREFETCH_EN
            if (w_pf_present) r_state <= IDLE;
            else begin
              r_state     <= PF_REQ;
              r_miss_addr <= w_pf_blk;
            end
`else
            r_state <= IDLE;
`endif
          end
`ifdef ICACHE_PREFETCH_EN
        PF_REQ:
          if (rollback) r_state <= IDLE;
          else if (!w_hit && !vcachehit) begin
            r_state     <= REQ;
            r_miss_addr <= proc2Icache_addr[`XLEN-1:3];
          end else if (w_bus_go && Imem2proc_response != 4'd0) begin
            r_state   <= PF_WAIT;
            r_mem_tag <= Imem2proc_response;
          end
        PF_WAIT:
          if (w_fill) begin
            r_state   <= IDLE;
            r_mem_tag <= '0;
          end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data/tag arrays carry no reset; valid bits gate them.
  always_ff @(posedge clock) begin
    if (!reset && w_fill) begin
      r_data[w_fset][w_fill_way] <= Imem2proc_data;
      r_tag[w_fset][w_fill_way]  <= w_ftag;
    end
  end

  assign proc2Imem_command = (!reset && w_bus_go) ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = {r_miss_addr, 3'b000};
  assign Icache_valid_out  = !reset && w_hit;
  assign Icache_data_out   = w_hit_data;
  assign victimen          = !reset && w_evict;
  assign victimidx         = victimen ? w_fset : '0;

  always_comb begin
    icache_vdata = '0;
    if (victimen) begin
      icache_vdata.data   = r_data[w_fset][w_fill_way];
      icache_vdata.tags   = PKT_TAG_W'(r_tag[w_fset][w_fill_way]);
      icache_vdata.valids = 1'b1;
    end
  end
endmodule
